// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle, sign fix-up, then hold in DONE.
// Latency XLEN+2 cycles (1 for divide-by-zero / signed overflow); in_ready only in IDLE, result held until out_ready.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]      rd_q;
  logic            rem_sel_q, neg_quo_q, neg_rem_q, out_valid_q;

  logic            signed_op, dvd_neg, dvs_neg, div_zero, overflow;
  logic [XLEN-1:0] dvd_abs, dvs_abs, rem_d, quo_d, quo_fix, rem_fix;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    signed_op = ~op[0];
    dvd_neg   = signed_op & dividend[XLEN-1];
    dvs_neg   = signed_op & divisor[XLEN-1];
    dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;
    div_zero  = (divisor == '0);
    overflow  = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    // The XLEN+1-bit difference's MSB is the borrow: set means the trial subtract failed.
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    rem_d     = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      rem_sel_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rd_q      <= rd_in;
            rem_sel_q <= op[1];
            if (div_zero) begin
              result_q    <= op[1] ? dividend : '1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (overflow) begin
              result_q    <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= dvd_abs;
              dvs_q     <= dvs_abs;
              cnt_q     <= '0;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= FIX;
        end
        FIX: begin
          result_q    <= rem_sel_q ? rem_fix : quo_fix;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against a plain-arithmetic RV32M division model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid, in_ready;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics: SV signed / and % truncate toward zero like RISC-V.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00: return 32'($signed(a) / $signed(b));
      2'b01: return a / b;
      2'b10: return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input string tag);
    logic [31:0] exp;
    int exp_lat, cyc;
    exp     = ref_model(o, a, b);
    exp_lat = (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; dividend = a; divisor = b; rd_in = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom; rd_in = 5'($urandom); op = 2'($urandom);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".result"}, result, exp);
    check({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_result"}, result, exp);
      check({tag, ".hold_rd"}, {27'd0, rd_out}, {27'd0, rd});
      check({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          seen;

    arst = 1'b1; in_valid = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.rd_out", {27'd0, rd_out}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    arst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, 0, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 5'd6, 0, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, "rem_m7_2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd9, 0, "rem_7_m2");
    run_op(2'b00, 32'h1234, 32'd0, 5'd10, 0, "div_by0");
    run_op(2'b01, 32'h1234, 32'd0, 5'd11, 0, "divu_by0");
    run_op(2'b10, 32'h1234, 32'd0, 5'd12, 0, "rem_by0");
    run_op(2'b11, 32'h1234, 32'd0, 5'd13, 0, "remu_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, "divu_big");
    run_op(2'b01, 32'hDEAD_BEEF, 32'd1234, 5'd17, 5, "hold");
    run_op(2'b01, 32'd50, 32'd5, 5'd18, 0, "after_hold");

    // Flush ten cycles into CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd19;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.busy", {31'd0, busy}, 32'd0);
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush.no_output", 32'(seen), 32'd0);

    // Flush together with a request in IDLE must not accept it.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; dividend = 32'hFFFF_0000; divisor = 32'd77; rd_in = 5'd21;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.in_ready", {31'd0, in_ready}, 32'd1);
    check("arst.out_valid", {31'd0, out_valid}, 32'd0);
    check("arst.result", result, 32'd0);
    check("arst.rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, 5'd22, 0, "divu_9_3");

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, 5'($urandom), n % 7 == 3 ? 2 : 0, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
